clkdiv_arbiter: RTL and testbench
=================================

# clkdiv_arbiter

Shares the single programmable clock divider between `NUM_REQ` requesters, each wanting its own divide setting. Round-robin arbitration picks a requester, programs the divider through its `wr`/`div_in` port, confirms the setting via `div_reg` readback, then grants ownership for at least `HOLD_TICKS` divider ticks before re-arbitrating. Sits between the divider and the PWM/peripheral blocks that consume its divided tick.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLK_DIV_SIZE`, 3: divider select width; must match the divider instance.
- `HOLD_TICKS`, 4: minimum divider ticks a grant is held when others are waiting, 1..255.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req`  in  NUM_REQ  per-requester request level; must stay high while owning.
- `req_div`  in  NUM_REQ*CLK_DIV_SIZE  packed settings; requester i at `[i*CLK_DIV_SIZE +: CLK_DIV_SIZE]`.
- `div_tick`  in  1  divider `clk_out` (one-cycle pulse per divided period).
- `div_rb`  in  CLK_DIV_SIZE  divider `div_reg` readback.
- `div_wr`  out  1  to divider `wr`.
- `div_out`  out  CLK_DIV_SIZE  to divider `div_in`.
- `grant`  out  NUM_REQ  one-hot ownership; all zero when unowned.
- `busy`  out  1  high in any state other than IDLE.
- `cfg_err`  out  1  sticky: readback mismatch seen; cleared only by `rst`.

## Operation
- States: IDLE, WRITE, CONFIRM, HOLD. Registers: state, owner index `idx`, round-robin pointer `ptr`, `div_out`, confirm timer (2 bits), tick counter (8 bits, saturating), `cfg_err`.
- IDLE: if any `req`, select the first set bit at or after `ptr` (wrapping); latch `idx`, `div_out <= req_div[idx]`; go WRITE. None: stay.
- WRITE: `div_wr = 1` for exactly this cycle; confirm timer cleared; go CONFIRM.
- CONFIRM: `div_rb == div_out` -> HOLD, tick counter <= 0, `ptr <= (idx+1) mod NUM_REQ`. Mismatch: timer increments; after 3 mismatching cycles set `cfg_err`, go WRITE (retry indefinitely). `req[idx]` dropped -> IDLE.
- HOLD: `grant[idx] = 1`. Tick counter increments on `div_tick`, saturates at `HOLD_TICKS`. Exits, priority order:
  1. `req[idx] == 0` -> IDLE.
  2. `req_div[idx] != div_out` -> latch new value, go WRITE (grant drops during rewrite, ptr unchanged on exit from HOLD, re-set on confirm).
  3. counter == `HOLD_TICKS` and any other `req` bit set -> IDLE (rotation).
  4. else stay; sole requester holds indefinitely.
- `grant`, `div_wr`, `busy` decoded from state/idx registers only; no combinational path from inputs to outputs.

## Timing
- Reset values: state IDLE, `idx` 0, `ptr` 0, `div_out` 0, `div_wr` 0, `grant` 0, `busy` 0, `cfg_err` 0.
- Request in IDLE at cycle 0 -> `div_wr` high cycle 1 -> readback checked cycle 2 -> `grant` high cycle 3 (3-cycle latency with a conforming divider).
- Release: `req[idx]` low at cycle n -> `grant` low cycle n+1; new arbitration in IDLE at n+1, next grant at n+4 earliest.
- `div_tick` coincident with HOLD exit is ignored. Grant never one-hot-violated; never two owners.
- `rst` mid-operation: immediate return to reset values; `div_wr` deasserts asynchronously.

## Structure
- Shared package `clkdiv_pkg`: state encodings (2-bit localparams), `CLK_DIV_SIZE` default, confirm-timeout constant (3).
- One sub-module: `rr_picker` (combinational round-robin first-set-bit from pointer, outputs index + valid). Top holds FSM and counters.

## Test plan
- Single requester: `req=0001`, `req_div[0]=3` -> `div_wr` pulse cycle 1, `div_out=3`, `grant=0001` cycle 3, held indefinitely.
- Rotation: reqs 0 and 2 high, `HOLD_TICKS=4` -> grant 0 released after 4th `div_tick`, grant `0100` 4 cycles later, then back to `0001`.
- Pointer fairness: all four request continuously -> grant order 0,1,2,3,0.
- Reconfig in HOLD: owner changes `req_div` 3->5 -> grant drops, `div_wr` pulse with `div_out=5`, grant returns after confirm.
- Bad readback: tie `div_rb=0`, request div 2 -> `cfg_err` set 3 cycles into CONFIRM, repeated WRITE pulses, no grant.
- Async reset asserted mid-HOLD -> `grant=0`, `busy=0`, `cfg_err=0` before next clock edge.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared constants and FSM encoding for the clock-divider arbiter.
package clkdiv_pkg;

    localparam int unsigned DEF_CLK_DIV_SIZE = 3;
    // Consecutive mismatching readback cycles tolerated before a rewrite.
    localparam int unsigned CONFIRM_TIMEOUT  = 3;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WRITE   = 2'd1;
    localparam logic [1:0] ST_CONFIRM = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    typedef enum logic [1:0] {
        StIdle    = ST_IDLE,
        StWrite   = ST_WRITE,
        StConfirm = ST_CONFIRM,
        StHold    = ST_HOLD
    } state_e;

endpackage

// File: rtl/clkdiv_arbiter_if.sv
// Requester and divider-side signals of the clock-divider arbiter.
interface clkdiv_arbiter_if import clkdiv_pkg::*; #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLK_DIV_SIZE = DEF_CLK_DIV_SIZE
) ();

    logic [NUM_REQ-1:0]              req;
    logic [NUM_REQ*CLK_DIV_SIZE-1:0] req_div;
    logic [NUM_REQ-1:0]              grant;
    logic                            div_tick;
    logic [CLK_DIV_SIZE-1:0]         div_rb;
    logic                            div_wr;
    logic [CLK_DIV_SIZE-1:0]         div_out;

    modport master (
        output req, req_div, div_tick, div_rb,
        input  grant, div_wr, div_out
    );

    modport slave (
        input  req, req_div, div_tick, div_rb,
        output grant, div_wr, div_out
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping.
module rr_picker #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IW = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      ptr,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    logic [IW:0] pos;

    always_comb begin
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        // Scan farthest-first so the hit nearest to ptr is the last one written.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr} + (IW + 1)'(k);
            if (pos >= (IW + 1)'(NUM_REQ)) begin
                pos = pos - (IW + 1)'(NUM_REQ);
            end
            if (req[pos[IW-1:0]]) begin
                idx   = pos[IW-1:0];
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clkdiv_arbiter.sv
// Round-robin owner of a shared programmable clock divider: program, confirm, then hold.
module clkdiv_arbiter import clkdiv_pkg::*; #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned CLK_DIV_SIZE = DEF_CLK_DIV_SIZE,
    parameter int unsigned HOLD_TICKS   = 4
) (
    input  logic             clk,
    input  logic             rst,
    clkdiv_arbiter_if.slave  bus,
    output logic             busy,
    output logic             cfg_err
);

    localparam int unsigned IW = $clog2(NUM_REQ);

    state_e                  state_q, state_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic [IW-1:0]           ptr_q, ptr_d;
    logic [CLK_DIV_SIZE-1:0] div_q, div_d;
    logic [1:0]              tmr_q, tmr_d;
    logic [7:0]              cnt_q, cnt_d;
    logic                    err_q, err_d;

    logic [IW-1:0]           pick_idx;
    logic                    pick_valid;
    logic [CLK_DIV_SIZE-1:0] pick_div;
    logic [CLK_DIV_SIZE-1:0] cur_div;
    logic [NUM_REQ-1:0]      own_mask;
    logic                    others_waiting;
    logic [IW-1:0]           ptr_inc;

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_picker (
        .req   (bus.req),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign pick_div       = bus.req_div[pick_idx * CLK_DIV_SIZE +: CLK_DIV_SIZE];
    assign cur_div        = bus.req_div[idx_q * CLK_DIV_SIZE +: CLK_DIV_SIZE];
    assign own_mask       = NUM_REQ'(1) << idx_q;
    assign others_waiting = |(bus.req & ~own_mask);
    assign ptr_inc        = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        div_d   = div_q;
        tmr_d   = tmr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    div_d   = pick_div;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                tmr_d   = '0;
                state_d = StConfirm;
            end
            StConfirm: begin
                if (!bus.req[idx_q]) begin
                    state_d = StIdle;
                end else if (bus.div_rb == div_q) begin
                    cnt_d   = '0;
                    ptr_d   = ptr_inc;
                    state_d = StHold;
                end else if (tmr_q == 2'(CONFIRM_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = StWrite;
                end else begin
                    tmr_d = tmr_q + 2'd1;
                end
            end
            StHold: begin
                if (bus.div_tick && (cnt_q != 8'(HOLD_TICKS))) begin
                    cnt_d = cnt_q + 8'd1;
                end
                if (!bus.req[idx_q]) begin
                    state_d = StIdle;
                end else if (cur_div != div_q) begin
                    div_d   = cur_div;
                    state_d = StWrite;
                end else if ((cnt_q == 8'(HOLD_TICKS)) && others_waiting) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            idx_q   <= '0;
            ptr_q   <= '0;
            div_q   <= '0;
            tmr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            div_q   <= div_d;
            tmr_q   <= tmr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Outputs come from registers only, so the divider and consumers see no input glitches.
    assign bus.div_wr  = (state_q == StWrite);
    assign bus.div_out = div_q;
    assign bus.grant   = (state_q == StHold) ? own_mask : '0;
    assign busy        = (state_q != StIdle);
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_clkdiv_arbiter.sv
// Self-checking bench for clkdiv_arbiter: vector table, directed corner cases, random vs model.
module tb_clkdiv_arbiter;

    localparam int N    = 4;
    localparam int W    = 3;
    localparam int HOLD = 4;

    localparam int P_IDLE    = 0;
    localparam int P_WRITE   = 1;
    localparam int P_CONFIRM = 2;
    localparam int P_HOLD    = 3;

    logic clk;
    logic rst;
    logic busy;
    logic cfg_err;
    logic bad;
    logic [W-1:0] div_reg;

    int n_chk;
    int n_fail;

    clkdiv_arbiter_if #(.NUM_REQ(N), .CLK_DIV_SIZE(W)) bus ();

    clkdiv_arbiter #(
        .NUM_REQ      (N),
        .CLK_DIV_SIZE (W),
        .HOLD_TICKS   (HOLD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .busy    (busy),
        .cfg_err (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in: latches div_in on wr; 'bad' forces a broken readback of zero.
    always @(posedge clk or posedge rst) begin
        if (rst) div_reg <= '0;
        else if (bus.div_wr) div_reg <= bus.div_out;
    end
    assign bus.div_rb = bad ? '0 : div_reg;

    typedef struct packed {
        logic [N-1:0]   req;
        logic [N*W-1:0] rdiv;
        logic           tick;
        logic [N-1:0]   e_grant;
        logic           e_wr;
        logic           e_busy;
        logic [W-1:0]   e_div;
    } vec_t;

    vec_t tbl [15];

    // Behavioural model state: phase, owner, rotation start, latched setting, ticks held.
    int           m_ph;
    int           m_own;
    int           m_rr;
    int           m_ticks;
    logic [W-1:0] m_div;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] slot(input logic [N*W-1:0] rd, input int i);
        return rd[i*W +: W];
    endfunction

    function automatic int first_from(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ph = P_IDLE; m_own = 0; m_rr = 0; m_ticks = 0; m_div = '0;
    endtask

    task automatic model_step(input logic [N-1:0] r, input logic [N*W-1:0] rd, input logic t);
        int c;
        logic [N-1:0] others;
        case (m_ph)
            P_IDLE: begin
                c = first_from(r, m_rr);
                if (c >= 0) begin
                    m_own = c; m_div = slot(rd, c); m_ph = P_WRITE;
                end
            end
            P_WRITE: m_ph = P_CONFIRM;
            P_CONFIRM: begin
                m_ph = P_HOLD; m_ticks = 0; m_rr = (m_own + 1) % N;
            end
            default: begin
                others = r;
                others[m_own] = 1'b0;
                if (!r[m_own]) m_ph = P_IDLE;
                else if (slot(rd, m_own) != m_div) begin
                    m_div = slot(rd, m_own); m_ph = P_WRITE;
                end else if (m_ticks == HOLD && others != '0) m_ph = P_IDLE;
                else if (t && m_ticks < HOLD) m_ticks++;
            end
        endcase
    endtask

    function automatic logic [N-1:0] model_grant();
        logic [N-1:0] g;
        g = '0;
        if (m_ph == P_HOLD) g[m_own] = 1'b1;
        return g;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0; bus.req_div = '0; bus.div_tick = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_grant(input logic nonzero, input int max_cyc, input string name);
        int n;
        n = 0;
        while (((bus.grant != '0) != nonzero) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        if (n >= max_cyc) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: timeout after %0d cycles, grant %0h", name, n, bus.grant);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] own_g [2];
        logic [N-1:0] nxt_g [2];
        logic [W-1:0] nxt_d [2];
        n_chk = 0; n_fail = 0; bad = 1'b0;

        // Single requester, saturating hold, reconfiguration, release.
        tbl[0]  = '{4'b0001, 12'h003, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{4'b0001, 12'h003, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd3};
        tbl[2]  = '{4'b0001, 12'h003, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd3};
        for (int i = 3; i < 9; i++) tbl[i] = '{4'b0001, 12'h003, 1'b1, 4'b0001, 1'b0, 1'b1, 3'd3};
        tbl[9]  = '{4'b0001, 12'h005, 1'b0, 4'b0001, 1'b0, 1'b1, 3'd3};
        tbl[10] = '{4'b0001, 12'h005, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd5};
        tbl[11] = '{4'b0001, 12'h005, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd5};
        tbl[12] = '{4'b0000, 12'h005, 1'b0, 4'b0001, 1'b0, 1'b1, 3'd5};
        tbl[13] = '{4'b0000, 12'h005, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd5};
        tbl[14] = '{4'b0000, 12'h005, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd5};

        do_reset();
        chk("reset cfg_err", 32'(cfg_err), 32'd0);
        for (int i = 0; i < 15; i++) begin
            chk($sformatf("vec%0d grant", i), 32'(bus.grant), 32'(tbl[i].e_grant));
            chk($sformatf("vec%0d div_wr", i), 32'(bus.div_wr), 32'(tbl[i].e_wr));
            chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].e_busy));
            chk($sformatf("vec%0d div_out", i), 32'(bus.div_out), 32'(tbl[i].e_div));
            bus.req = tbl[i].req; bus.req_div = tbl[i].rdiv; bus.div_tick = tbl[i].tick;
            @(negedge clk);
        end

        // Rotation between requesters 0 and 2.
        do_reset();
        bus.req = 4'b0101;
        bus.req_div = {3'd0, 3'd6, 3'd0, 3'd3};
        repeat (3) @(negedge clk);
        chk("rot first grant", 32'(bus.grant), 32'h1);
        own_g[0] = 4'b0001; nxt_g[0] = 4'b0100; nxt_d[0] = 3'd6;
        own_g[1] = 4'b0100; nxt_g[1] = 4'b0001; nxt_d[1] = 3'd3;
        for (int rnd = 0; rnd < 2; rnd++) begin
            repeat (4) begin
                bus.div_tick = 1'b1;
                @(negedge clk);
            end
            bus.div_tick = 1'b0;
            chk($sformatf("rot%0d held", rnd), 32'(bus.grant), 32'(own_g[rnd]));
            @(negedge clk);
            chk($sformatf("rot%0d release", rnd), 32'(bus.grant), 32'h0);
            @(negedge clk);
            chk($sformatf("rot%0d div_wr", rnd), 32'(bus.div_wr), 32'd1);
            chk($sformatf("rot%0d div_out", rnd), 32'(bus.div_out), 32'(nxt_d[rnd]));
            repeat (2) @(negedge clk);
            chk($sformatf("rot%0d next grant", rnd), 32'(bus.grant), 32'(nxt_g[rnd]));
        end

        // Pointer fairness with all four requesting.
        do_reset();
        bus.req = 4'b1111;
        bus.req_div = {3'd4, 3'd3, 3'd2, 3'd1};
        bus.div_tick = 1'b1;
        for (int o = 0; o < 5; o++) begin
            wait_grant(1'b1, 20, $sformatf("fair%0d wait grant", o));
            chk($sformatf("fair%0d owner", o), 32'(bus.grant), 32'(1 << (o % N)));
            wait_grant(1'b0, 20, $sformatf("fair%0d wait release", o));
        end

        // Broken readback: timeout, sticky error, retries, then recovery and async reset.
        bad = 1'b1;
        do_reset();
        bus.req = 4'b0010;
        bus.req_div = {3'd0, 3'd0, 3'd2, 3'd0};
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            chk($sformatf("bad c%0d grant", c), 32'(bus.grant), 32'h0);
            chk($sformatf("bad c%0d div_wr", c), 32'(bus.div_wr),
                32'((c == 1) || (c == 5) || (c == 9)));
            chk($sformatf("bad c%0d cfg_err", c), 32'(cfg_err), 32'(c >= 5));
        end
        bad = 1'b0;
        repeat (2) @(negedge clk);
        chk("recover grant", 32'(bus.grant), 32'h2);
        chk("recover cfg_err sticky", 32'(cfg_err), 32'd1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async rst grant", 32'(bus.grant), 32'h0);
        chk("async rst busy", 32'(busy), 32'd0);
        chk("async rst cfg_err", 32'(cfg_err), 32'd0);

        // Async reset during a write pulse.
        do_reset();
        bus.req = 4'b0001;
        bus.req_div = {3'd0, 3'd0, 3'd0, 3'd7};
        @(negedge clk);
        chk("wr pulse before rst", 32'(bus.div_wr), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("async rst div_wr", 32'(bus.div_wr), 32'd0);

        // Random traffic against the behavioural model; owner keeps req high until it holds.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk($sformatf("rand c%0d outputs", cyc),
                32'({bus.grant, bus.div_wr, busy, cfg_err, bus.div_out}),
                32'({model_grant(), m_ph == P_WRITE, m_ph != P_IDLE, 1'b0, m_div}));
            r = bus.req;
            for (int i = 0; i < N; i++) begin
                if (m_ph == P_HOLD && i == m_own) begin
                    if ($urandom_range(31) == 0) r[i] = ~r[i];
                end else if ($urandom_range(7) == 0) begin
                    r[i] = ~r[i];
                end
            end
            if (m_ph == P_WRITE || m_ph == P_CONFIRM) r[m_own] = 1'b1;
            bus.req = r;
            if ($urandom_range(15) == 0) begin
                bus.req_div[$urandom_range(N - 1) * W +: W] = W'($urandom);
            end
            bus.div_tick = ($urandom_range(2) == 0);
            model_step(bus.req, bus.req_div, bus.div_tick);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
